// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file: r0 reads zero, same-cycle write forwarding, post-reset clear sequencer.
// Latency: reads are combinational (0 cycles with forwarding), writes land in the array on the next edge.
// No backpressure: ready stays low during the 2**ADDR_W-cycle clear; writes/issues are ignored until then.
// Optional: define REGFILE_SCOREBOARD_EN to build the per-register busy scoreboard (rbusy, iss_en/iss_addr).
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic [NUM_RD-1:0]          re,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic [NUM_RD-1:0]          rbusy,
  output logic                       ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;
  localparam logic [ADDR_W-1:0] ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [DATA_W-1:0]   regs [DEPTH];
  logic                wr0_ok;
  logic                wr1_ok;

  // Writes only take effect once the file is ready; r0 is never stored.
  assign wr0_ok = (state == READY) && we0 && (waddr0 != '0);
  assign wr1_ok = (state == READY) && we1 && (waddr1 != '0);

  // Clear sequencer: walk every entry once after reset, then sit in READY until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + ONE;
          if (clr_ptr == LAST_IDX) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= READY;
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Array update: zero fill during CLEAR, otherwise both lanes; lane 1 is written last so it wins on a tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[clr_ptr] <= '0;
      end else begin
        if (wr0_ok) regs[waddr0] <= wdata0;
        if (wr1_ok) regs[waddr1] <= wdata1;
      end
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] busy;

  // Scoreboard: retire clears, issue sets; the set is applied last because the issuing op is the newer producer.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (state == READY) begin
      if (we0) busy[waddr0] <= 1'b0;
      if (we1) busy[waddr1] <= 1'b0;
      if (iss_en && (iss_addr != '0)) busy[iss_addr] <= 1'b1;
    end
  end
`else
  logic unused_iss;
  assign unused_iss = ^{iss_en, iss_addr};
`endif

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit0;
    logic              hit1;
    logic              rd_live;

    assign ra      = raddr[g*ADDR_W +: ADDR_W];
    assign hit0    = we0 && (waddr0 == ra);
    assign hit1    = we1 && (waddr1 == ra);
    assign rd_live = (state == READY) && (ra != '0) && re[g];

    assign rdata[g*DATA_W +: DATA_W] = !rd_live ? '0     :
                                       hit1     ? wdata1 :
                                       hit0     ? wdata0 :
                                                  regs[ra];
`ifdef REGFILE_SCOREBOARD_EN
    // A retiring write to the same register is forwarded, so it already counts as not busy.
    assign rbusy[g] = rd_live && busy[ra] && !hit0 && !hit1;
`else
    assign rbusy[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset/clear timing, forwarding, lane priority, r0, scoreboard, mid-clear reset.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            we0, we1;
  logic [AW-1:0]   waddr0, waddr1;
  logic [DW-1:0]   wdata0, wdata1;
  logic [NR-1:0]   re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic            iss_en;
  logic [AW-1:0]   iss_addr;
  logic [NR-1:0]   rbusy;
  logic            ready;

  int checks = 0;
  int errors = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata),
    .iss_en(iss_en), .iss_addr(iss_addr), .rbusy(rbusy), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sel(input int p, input logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  function automatic logic [31:0] rd(input int p);
    return rdata[p*DW +: DW];
  endfunction

  task automatic idle;
    we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; iss_addr = '0;
  endtask

  // Counts 32 edges after rst was released; ready must rise exactly on the last one.
  task automatic clear_seq(input string tag);
    for (int c = 1; c <= 32; c++) begin
      tick();
      check($sformatf("%s_ready_c%0d", tag, c), 32'(ready), 32'(c == 32));
      if (c < 32) check($sformatf("%s_rd0_c%0d", tag, c), rd(0), 32'h0);
      if (c == 20) idle();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    re = '1;
    raddr = '0;
    sel(0, 5'd3); sel(1, 5'd5); sel(2, 5'd31); sel(3, 5'd1);
    tick(); tick();
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_rdata2", rd(2), 32'h0);
    check("rst_rbusy", 32'(rbusy), 32'h0);

    // Writes and issues during CLEAR must be ignored.
    rst = 1'b0;
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD;
    iss_en = 1'b1; iss_addr = 5'd6;
    sel(0, 5'd5);
    #1;
    check("clr_fwd_blocked", rd(0), 32'h0);
    check("clr_rbusy", 32'(rbusy), 32'h0);
    clear_seq("clr1");

    re = 4'b0001;
    for (int r = 1; r < 32; r++) begin
      sel(0, AW'(r));
      #1;
      check($sformatf("post_clr_r%0d", r), rd(0), 32'h0);
    end
    sel(0, 5'd6);
    #1;
    check("clr_issue_dropped", 32'(rbusy[0]), 32'h0);

    // Lane-0 write forwarded to port 2 in the same cycle, then read from the array.
    re = 4'b0100;
    sel(2, 5'd5);
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1234;
    #1;
    check("fwd0_same", rd(2), 32'h1234);
    tick(); idle(); #1;
    check("fwd0_stored", rd(2), 32'h1234);

    // Both lanes to r7: lane 1 wins, both forwarded and stored; disabled port reads 0.
    re = 4'b0010;
    sel(0, 5'd7); sel(1, 5'd7);
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hAAAA;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h5555;
    #1;
    check("tie_fwd", rd(1), 32'h5555);
    check("re_off", rd(0), 32'h0);
    tick(); idle(); #1;
    check("tie_stored", rd(1), 32'h5555);

    // Independent lanes to different registers.
    re = 4'b0011;
    sel(0, 5'd10); sel(1, 5'd11);
    we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'h0000_00A0;
    we1 = 1'b1; waddr1 = 5'd11; wdata1 = 32'h0000_0B11;
    #1;
    check("dual_fwd0", rd(0), 32'h0000_00A0);
    check("dual_fwd1", rd(1), 32'h0000_0B11);
    tick(); idle(); #1;
    check("dual_st0", rd(0), 32'h0000_00A0);
    check("dual_st1", rd(1), 32'h0000_0B11);

    // r0 is never written nor forwarded.
    re = 4'b1000;
    sel(3, 5'd0);
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF;
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hEEEE;
    #1;
    check("r0_fwd", rd(3), 32'h0);
    tick(); idle(); #1;
    check("r0_stored", rd(3), 32'h0);

    re = 4'b0001;
    sel(0, 5'd9);
`ifdef REGFILE_SCOREBOARD_EN
    iss_en = 1'b1; iss_addr = 5'd9;
    #1;
    check("sb_set_not_yet", 32'(rbusy[0]), 32'h0);
    tick(); idle(); #1;
    check("sb_busy", 32'(rbusy[0]), 32'h1);
    re = 4'b0000;
    #1;
    check("sb_re_off", 32'(rbusy[0]), 32'h0);
    re = 4'b0001;
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h99;
    #1;
    check("sb_clr_same", 32'(rbusy[0]), 32'h0);
    check("sb_clr_fwd", rd(0), 32'h99);
    tick(); idle(); #1;
    check("sb_clr_after", 32'(rbusy[0]), 32'h0);
    iss_en = 1'b1; iss_addr = 5'd9;
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h77;
    #1;
    check("sb_setclr_same", 32'(rbusy[0]), 32'h0);
    tick(); idle(); #1;
    check("sb_set_wins", 32'(rbusy[0]), 32'h1);
    check("sb_set_wins_dat", rd(0), 32'h77);
    iss_en = 1'b1; iss_addr = 5'd0;
    sel(0, 5'd0);
    tick(); idle(); #1;
    check("sb_r0", 32'(rbusy[0]), 32'h0);
`else
    sel(0, 5'd4);
    iss_en = 1'b1; iss_addr = 5'd4;
    tick(); idle(); #1;
    check("nosb_rbusy", 32'(rbusy[0]), 32'h0);
    tick(); #1;
    check("nosb_rbusy2", 32'(rbusy), 32'h0);
`endif

    // Issue r3, reset, abort clear at cycle 10, then full clear again.
    iss_en = 1'b1; iss_addr = 5'd3;
    tick(); idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) tick();
    check("mid_clr_ready", 32'(ready), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    re = 4'b0011;
    sel(0, 5'd3); sel(1, 5'd5);
    clear_seq("clr2");
    check("rst_busy3", 32'(rbusy[0]), 32'h0);
    check("rst_r5_zero", rd(1), 32'h0);
    check("rst_r3_zero", rd(0), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
